// File: rtl/rfblackwidow_mem_req_drain_if.sv
// Request record type plus the queue/bus/response bundle of the memory request drain.
// master = drain side, slave = environment (queue, bus fabric, response consumer).
package rfblackwidow_mem_req_pkg;
    localparam logic [3:0] MR_LOAD  = 4'h0;
    localparam logic [3:0] MR_LOADZ = 4'h1;
    localparam logic [3:0] MR_STORE = 4'h2;

    localparam logic [2:0] SZ_BYT   = 3'd0;
    localparam logic [2:0] SZ_WYDE  = 3'd1;
    localparam logic [2:0] SZ_TETRA = 3'd2;
    localparam logic [2:0] SZ_OCTA  = 3'd3;
    localparam logic [2:0] SZ_HEXI  = 3'd4;

    typedef struct packed {
        logic [7:0]   tid;
        logic [3:0]   func;
        logic [2:0]   size;
        logic [63:0]  adr;
        logic [127:0] dat;
    } MemoryRequest;
endpackage

interface rfblackwidow_mem_req_drain_if #(parameter int AWID = 32);
    import rfblackwidow_mem_req_pkg::*;

    MemoryRequest      req_i;
    logic              req_valid_i;
    logic              req_rd_o;
    logic              cyc_o;
    logic              stb_o;
    logic              we_o;
    logic [15:0]       sel_o;
    logic [AWID-1:0]   adr_o;
    logic [127:0]      dat_o;
    logic              ack_i;
    logic              err_i;
    logic [127:0]      dat_i;
    MemoryRequest      resp_o;
    logic              resp_valid_o;
    logic              resp_ready_i;
    logic              resp_err_o;
    logic              busy_o;

    modport master (
        input  req_i, req_valid_i, ack_i, err_i, dat_i, resp_ready_i,
        output req_rd_o, cyc_o, stb_o, we_o, sel_o, adr_o, dat_o,
               resp_o, resp_valid_o, resp_err_o, busy_o
    );

    modport slave (
        output req_i, req_valid_i, ack_i, err_i, dat_i, resp_ready_i,
        input  req_rd_o, cyc_o, stb_o, we_o, sel_o, adr_o, dat_o,
               resp_o, resp_valid_o, resp_err_o, busy_o
    );
endinterface

// File: rtl/rfblackwidow_mem_req_drain.sv
// Pops one memory request at a time, runs a single bus cycle for it and presents the response.
// Latency: pop clock + one clock per bus wait + response clock (3 minimum); optional RFBW_MEM_REQ_DRAIN_TIMEOUT_EN bus timeout.
// Backpressure: no pop while busy; response held until resp_ready_i, bus held until ack_i/err_i.
module rfblackwidow_mem_req_drain
    import rfblackwidow_mem_req_pkg::*;
#(
    parameter int AWID = 32,
    parameter int TOUT = 16
) (
    input logic                          clk,
    input logic                          rst,
    rfblackwidow_mem_req_drain_if.master bus
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUS  = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    if (TOUT < 1 || TOUT > 255 || AWID < 5 || AWID > 64) begin : g_bad_param
        $error("rfblackwidow_mem_req_drain: TOUT must be 1..255 and AWID 5..64");
    end

    function automatic logic [15:0] f_lanes(input logic [2:0] sz);
        case (sz)
            SZ_BYT:   f_lanes = 16'h0001;
            SZ_WYDE:  f_lanes = 16'h0003;
            SZ_TETRA: f_lanes = 16'h000F;
            SZ_OCTA:  f_lanes = 16'h00FF;
            SZ_HEXI:  f_lanes = 16'hFFFF;
            default:  f_lanes = 16'h00FF;
        endcase
    endfunction

    logic [1:0]       r_state;
    MemoryRequest     r_resp;
    logic             r_err;
    logic             r_cyc;
    logic             r_we;
    logic [15:0]      r_sel;
    logic [AWID-1:0]  r_adr;
    logic [127:0]     r_dat;

    logic             w_func_ok;
    logic             w_tout;
    logic [15:0]      w_ld_lanes;
    logic [127:0]     w_ld_raw;
    logic [127:0]     w_ld_mask;
    logic             w_ld_sign;
    logic [127:0]     w_ld_dat;

    assign w_func_ok = (bus.req_i.func == MR_LOAD) || (bus.req_i.func == MR_LOADZ) ||
                       (bus.req_i.func == MR_STORE);

    // Load alignment: bring the addressed lane down to byte 0, keep only the access size.
    always_comb begin
        w_ld_mask  = '0;
        w_ld_lanes = f_lanes(r_resp.size);
        w_ld_raw   = bus.dat_i >> {r_resp.adr[3:0], 3'b000};
        for (int i = 0; i < 16; i++) begin
            w_ld_mask[i*8 +: 8] = {8{w_ld_lanes[i]}};
        end
        case (r_resp.size)
            SZ_BYT:   w_ld_sign = w_ld_raw[7];
            SZ_WYDE:  w_ld_sign = w_ld_raw[15];
            SZ_TETRA: w_ld_sign = w_ld_raw[31];
            SZ_HEXI:  w_ld_sign = w_ld_raw[127];
            default:  w_ld_sign = w_ld_raw[63];
        endcase
        w_ld_dat = w_ld_raw & w_ld_mask;
        if (r_resp.func == MR_LOAD && w_ld_sign) begin
            w_ld_dat = w_ld_dat | ~w_ld_mask;
        end
    end

`ifdef RFBW_MEM_REQ_DRAIN_TIMEOUT_EN
    logic [7:0] r_tcnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_tcnt <= 8'd0;
        end else if (r_state == S_IDLE) begin
            r_tcnt <= 8'd0;
        end else if (r_state == S_BUS && !bus.ack_i && !bus.err_i) begin
            r_tcnt <= r_tcnt + 8'd1;
        end
    end

    // Fires in the TOUT-th bus clock; an ack in that same clock still completes cleanly.
    assign w_tout = (r_state == S_BUS) && (r_tcnt == 8'(TOUT - 1));
`else
    assign w_tout = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_resp  <= '0;
            r_err   <= 1'b0;
            r_cyc   <= 1'b0;
            r_we    <= 1'b0;
            r_sel   <= 16'h0;
            r_adr   <= '0;
            r_dat   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.req_valid_i) begin
                        r_resp <= bus.req_i;
                        if (w_func_ok) begin
                            r_state <= S_BUS;
                            r_err   <= 1'b0;
                            r_cyc   <= 1'b1;
                            r_we    <= (bus.req_i.func == MR_STORE);
                            r_sel   <= f_lanes(bus.req_i.size) << bus.req_i.adr[3:0];
                            r_adr   <= {bus.req_i.adr[AWID-1:4], 4'h0};
                            r_dat   <= bus.req_i.dat << {bus.req_i.adr[3:0], 3'b000};
                        end else begin
                            r_state <= S_RESP;
                            r_err   <= 1'b1;
                        end
                    end
                end
                S_BUS: begin
                    if (bus.ack_i || bus.err_i || w_tout) begin
                        r_state <= S_RESP;
                        r_cyc   <= 1'b0;
                        r_we    <= 1'b0;
                        r_sel   <= 16'h0;
                        r_err   <= bus.err_i || (!bus.ack_i && w_tout);
                        if (bus.ack_i && !bus.err_i && !r_we) begin
                            r_resp.dat <= w_ld_dat;
                        end
                    end
                end
                S_RESP: begin
                    if (bus.resp_ready_i) begin
                        r_state <= S_IDLE;
                        r_err   <= 1'b0;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Pop is qualified by rst so a valid queue head cannot strobe while reset is held.
    assign bus.req_rd_o     = rst && (r_state == S_IDLE) && bus.req_valid_i;
    assign bus.cyc_o        = r_cyc;
    assign bus.stb_o        = r_cyc;
    assign bus.we_o         = r_we;
    assign bus.sel_o        = r_sel;
    assign bus.adr_o        = r_adr;
    assign bus.dat_o        = r_dat;
    assign bus.resp_o       = r_resp;
    assign bus.resp_valid_o = (r_state == S_RESP);
    assign bus.resp_err_o   = r_err;
    assign bus.busy_o       = (r_state != S_IDLE);

endmodule

// File: tb/tb_rfblackwidow_mem_req_drain.sv
// Randomized bench for rfblackwidow_mem_req_drain with a byte-lane reference model and per-cycle output compare.
`timescale 1ns/1ps
module tb_rfblackwidow_mem_req_drain;
    import rfblackwidow_mem_req_pkg::*;

    localparam int AWID = 32;
    localparam int TOUT = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    rfblackwidow_mem_req_drain_if #(.AWID(AWID)) bus_if ();

    rfblackwidow_mem_req_drain #(.AWID(AWID), .TOUT(TOUT)) dut (
        .clk (clk),
        .rst (rst_n),
        .bus (bus_if)
    );

    int n_checks = 0;
    int n_err    = 0;
    int pop_cnt  = 0;
    bit chk_en   = 1'b0;

    MemoryRequest    exp_resp;
    logic            exp_err;
    logic            exp_func_ok;
    logic            exp_we;
    logic [15:0]     exp_sel;
    logic [AWID-1:0] exp_adr;
    logic [127:0]    exp_dat;

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic int nbytes(input logic [2:0] sz);
        case (sz)
            SZ_BYT:   return 1;
            SZ_WYDE:  return 2;
            SZ_TETRA: return 4;
            SZ_HEXI:  return 16;
            default:  return 8;
        endcase
    endfunction

    function automatic logic [15:0] m_sel(input MemoryRequest r);
        logic [15:0] s = '0;
        int off = int'(r.adr[3:0]);
        for (int b = 0; b < nbytes(r.size); b++) if (off + b < 16) s[off + b] = 1'b1;
        return s;
    endfunction

    function automatic logic [127:0] m_wdat(input MemoryRequest r);
        logic [127:0] d = '0;
        int off = int'(r.adr[3:0]);
        for (int b = 0; b < 16; b++) if (off + b < 16) d[(off + b) * 8 +: 8] = r.dat[b * 8 +: 8];
        return d;
    endfunction

    function automatic logic [127:0] m_ldat(input MemoryRequest r, input logic [127:0] di);
        logic [127:0] d = '0;
        int off = int'(r.adr[3:0]);
        int n = nbytes(r.size);
        for (int b = 0; b < n; b++) if (off + b < 16) d[b * 8 +: 8] = di[(off + b) * 8 +: 8];
        if (r.func == MR_LOAD && d[n * 8 - 1]) for (int i = n * 8; i < 128; i++) d[i] = 1'b1;
        return d;
    endfunction

    function automatic MemoryRequest mk(input logic [3:0] f, input logic [2:0] sz,
                                        input logic [63:0] a, input logic [127:0] d);
        MemoryRequest r;
        r.tid  = 8'($urandom);
        r.func = f;
        r.size = sz;
        r.adr  = a;
        r.dat  = d;
        return r;
    endfunction

    task automatic set_exp(input MemoryRequest r);
        exp_func_ok = (r.func == MR_LOAD) || (r.func == MR_LOADZ) || (r.func == MR_STORE);
        exp_we      = (r.func == MR_STORE);
        exp_sel     = m_sel(r);
        exp_adr     = {r.adr[AWID-1:4], 4'h0};
        exp_dat     = m_wdat(r);
        exp_resp    = r;
        exp_err     = !exp_func_ok;
    endtask

    // Single compare process: bus outputs during a cycle, response while presented, pop rules always.
    always @(negedge clk) begin
        if (chk_en && rst_n) begin
            if (bus_if.req_rd_o) pop_cnt++;
            if (bus_if.busy_o) chk("pop_while_busy", 256'(bus_if.req_rd_o), 256'(0));
            if (bus_if.cyc_o) begin
                chk("cyc_only_valid_func", 256'(bus_if.cyc_o), 256'(exp_func_ok));
                chk("stb", 256'(bus_if.stb_o), 256'(1));
                chk("we", 256'(bus_if.we_o), 256'(exp_we));
                chk("sel", 256'(bus_if.sel_o), 256'(exp_sel));
                chk("adr", 256'(bus_if.adr_o), 256'(exp_adr));
                chk("wdat", 256'(bus_if.dat_o), 256'(exp_dat));
            end
            if (bus_if.resp_valid_o) begin
                chk("resp", 256'(bus_if.resp_o), 256'(exp_resp));
                chk("resp_err", 256'(bus_if.resp_err_o), 256'(exp_err));
            end
        end
    end

    // kind: 0 ack, 1 err, 2 ack+err together, 3 no termination (timeout build only)
    task automatic do_txn(input MemoryRequest r, input int kind, input int term_at,
                          input int ready_wait, input logic [127:0] din,
                          output logic [15:0] o_sel, output logic [127:0] o_dat, output logic o_we,
                          output MemoryRequest o_resp, output logic o_err);
        int n;
        int exp_bclks;
        o_sel = '0; o_dat = '0; o_we = 1'b0;
        exp_bclks = (kind == 3) ? TOUT : term_at;
        @(posedge clk); #1;
        set_exp(r);
        if (kind == 3) exp_err = 1'b1;
        pop_cnt = 0;
        bus_if.req_i = r;
        bus_if.req_valid_i = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!bus_if.req_rd_o && n < 20);
        chk("pop_seen", 256'(bus_if.req_rd_o), 256'(1));
        @(posedge clk); #1;
        bus_if.req_valid_i = 1'b0;
        n = 0;
        if (exp_func_ok) begin
            for (int g = 0; g < 80; g++) begin
                @(negedge clk);
                if (!bus_if.cyc_o) break;
                n++;
                if (n == 1) begin o_sel = bus_if.sel_o; o_dat = bus_if.dat_o; o_we = bus_if.we_o; end
                if (n == term_at && kind != 3) begin
                    bus_if.dat_i = din;
                    bus_if.ack_i = (kind == 0 || kind == 2);
                    bus_if.err_i = (kind == 1 || kind == 2);
                    exp_err = (kind != 0);
                    if (kind == 0 && !exp_we) exp_resp.dat = m_ldat(r, din);
                    @(posedge clk); #1;
                    bus_if.ack_i = 1'b0;
                    bus_if.err_i = 1'b0;
                end
            end
            chk("bus_clocks", 256'(n), 256'(exp_bclks));
        end else begin
            chk("invalid_no_cyc", 256'(bus_if.cyc_o), 256'(0));
        end
        n = 0;
        while (!bus_if.resp_valid_o && n < 10) begin @(negedge clk); n++; end
        chk("resp_valid", 256'(bus_if.resp_valid_o), 256'(1));
        o_resp = bus_if.resp_o;
        o_err  = bus_if.resp_err_o;
        // Another head waits in the queue; it must not be popped before the response drains.
        bus_if.req_i = mk(MR_STORE, SZ_OCTA, {$urandom, $urandom}, '1);
        bus_if.req_valid_i = 1'b1;
        repeat (ready_wait) @(negedge clk);
        @(posedge clk); #1;
        bus_if.resp_ready_i = 1'b1;
        @(posedge clk); #1;
        bus_if.resp_ready_i = 1'b0;
        bus_if.req_valid_i  = 1'b0;
        @(negedge clk);
        chk("idle_after_resp", 256'(bus_if.busy_o), 256'(0));
        chk("pops_per_req", 256'(pop_cnt), 256'(1));
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        MemoryRequest r;
        MemoryRequest o_resp;
        logic [15:0]  o_sel;
        logic [127:0] o_dat;
        logic         o_we;
        logic         o_err;
        logic [3:0]   f;

        bus_if.req_i        = mk(MR_LOAD, SZ_OCTA, 64'h40, 128'h5);
        bus_if.req_valid_i  = 1'b1;
        bus_if.ack_i        = 1'b0;
        bus_if.err_i        = 1'b0;
        bus_if.dat_i        = '0;
        bus_if.resp_ready_i = 1'b0;
        #23;
        chk("rst_rd", 256'(bus_if.req_rd_o), 256'(0));
        chk("rst_cyc", 256'(bus_if.cyc_o), 256'(0));
        chk("rst_sel", 256'(bus_if.sel_o), 256'(0));
        chk("rst_busy", 256'(bus_if.busy_o), 256'(0));
        chk("rst_resp_valid", 256'(bus_if.resp_valid_o), 256'(0));
        chk("rst_resp", 256'(bus_if.resp_o), 256'(0));
        @(posedge clk); #1;
        rst_n = 1'b1;
        bus_if.req_valid_i = 1'b0;
        chk_en = 1'b1;

        do_txn(mk(MR_STORE, SZ_OCTA, 64'h1008, 128'h1122334455667788), 0, 2, 0, '0,
               o_sel, o_dat, o_we, o_resp, o_err);
        chk("store_sel_lit", 256'(o_sel), 256'(16'hFF00));
        chk("store_dat_hi_lit", 256'(o_dat[127:64]), 256'(64'h1122334455667788));
        chk("store_we_lit", 256'(o_we), 256'(1));
        chk("store_err_lit", 256'(o_err), 256'(0));
        chk("store_resp_dat_lit", 256'(o_resp.dat), 256'(128'h1122334455667788));

        do_txn(mk(MR_LOAD, SZ_BYT, 64'h2003, '0), 0, 1, 0, 128'h80 << 24,
               o_sel, o_dat, o_we, o_resp, o_err);
        chk("load_sext_lit", 256'(o_resp.dat), 256'(128'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFF80));
        do_txn(mk(MR_LOADZ, SZ_BYT, 64'h2003, '0), 0, 1, 0, 128'h80 << 24,
               o_sel, o_dat, o_we, o_resp, o_err);
        chk("loadz_lit", 256'(o_resp.dat), 256'(128'h80));

        do_txn(mk(MR_LOAD, SZ_TETRA, 64'h3004, '0), 2, 2, 5, {4{$urandom}},
               o_sel, o_dat, o_we, o_resp, o_err);
        chk("err_ack_lit", 256'(o_err), 256'(1));

        do_txn(mk(MR_LOAD, SZ_WYDE, 64'h500E, '0), 0, 16, 0, {4{$urandom}},
               o_sel, o_dat, o_we, o_resp, o_err);
        chk("ack_at_16_lit", 256'(o_err), 256'(0));
`ifdef RFBW_MEM_REQ_DRAIN_TIMEOUT_EN
        do_txn(mk(MR_LOAD, SZ_OCTA, 64'h6000, '0), 3, 0, 0, '0,
               o_sel, o_dat, o_we, o_resp, o_err);
        chk("timeout_err_lit", 256'(o_err), 256'(1));
`endif

        // Reset in the middle of a bus cycle: abandoned without response.
        @(posedge clk); #1;
        r = mk(MR_LOADZ, SZ_HEXI, 64'h7000, '0);
        set_exp(r);
        bus_if.req_i = r;
        bus_if.req_valid_i = 1'b1;
        @(negedge clk);
        @(posedge clk); #1;
        bus_if.req_valid_i = 1'b0;
`ifdef RFBW_MEM_REQ_DRAIN_TIMEOUT_EN
        repeat (5) @(negedge clk);
`else
        repeat (40) @(negedge clk);
`endif
        chk("bus_waits_for_ack", 256'(bus_if.cyc_o), 256'(1));
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_cyc", 256'(bus_if.cyc_o), 256'(0));
        chk("arst_resp_valid", 256'(bus_if.resp_valid_o), 256'(0));
        chk("arst_busy", 256'(bus_if.busy_o), 256'(0));
        chk("arst_adr", 256'(bus_if.adr_o), 256'(0));
        @(posedge clk); #1;
        rst_n = 1'b1;

        do_txn(mk(MR_STORE, SZ_WYDE, 64'h800F, 128'hBEEF), 0, 1, 0, '0,
               o_sel, o_dat, o_we, o_resp, o_err);
        chk("post_rst_sel_lit", 256'(o_sel), 256'(16'h8000));
        do_txn(mk(4'hF, SZ_OCTA, 64'h9000, 128'h1234), 0, 1, 1, '0,
               o_sel, o_dat, o_we, o_resp, o_err);
        chk("invalid_err_lit", 256'(o_err), 256'(1));

        for (int t = 0; t < 60; t++) begin
            case ($urandom_range(0, 4))
                0:       f = MR_LOAD;
                1:       f = MR_LOADZ;
                2, 3:    f = MR_STORE;
                default: f = 4'($urandom_range(3, 15));
            endcase
            r = mk(f, 3'($urandom_range(0, 7)), {$urandom, $urandom},
                   {$urandom, $urandom, $urandom, $urandom});
            do_txn(r, ($urandom_range(0, 4) < 3) ? 0 : int'($urandom_range(1, 2)),
                   int'($urandom_range(1, 6)), int'($urandom_range(0, 3)),
                   {$urandom, $urandom, $urandom, $urandom},
                   o_sel, o_dat, o_we, o_resp, o_err);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule

// File: doc/rfblackwidow_mem_req_drain.md
RFBLACKWIDOW_MEM_REQ_DRAIN -- requirements
Module: rfBlackWidow_mem_req_drain

Interface
REQ-001 SHALL have parameter AWID, default 32, address width.
REQ-002 SHALL have parameter TOUT, default 16, bus timeout in clocks (1..255).
REQ-003 SHALL have port clk  input  1  sole clock; all state changes on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port req_i  input  MemoryRequest  head of memory request queue.
REQ-006 SHALL have port req_valid_i  input  1  queue head valid.
REQ-007 SHALL have port req_rd_o  output  1  one-clock pop strobe to queue.
REQ-008 SHALL have port cyc_o, stb_o, we_o  output  1 each  bus cycle, strobe, write enable.
REQ-009 SHALL have port sel_o  output  16  byte lane selects.
REQ-010 SHALL have port adr_o  output  AWID  bus address.
REQ-011 SHALL have port dat_o  output  128  write data.
REQ-012 SHALL have port ack_i, err_i  input  1 each  bus acknowledge, bus error.
REQ-013 SHALL have port dat_i  input  128  read data.
REQ-014 SHALL have port resp_o  output  MemoryRequest  completed request (tid, func, adr, dat).
REQ-015 SHALL have port resp_valid_o  output  1;  resp_ready_i  input  1;  resp_err_o  output  1.
REQ-016 SHALL have port busy_o  output  1  high whenever state is not IDLE.

Function
REQ-017 SHALL implement FSM IDLE, BUS, RESP.
REQ-018 IDLE: when req_valid_i=1, SHALL capture req_i, assert req_rd_o for exactly one clock, go to BUS; never pops outside IDLE.
REQ-019 func MR_STORE SHALL drive we_o=1; MR_LOAD/MR_LOADZ SHALL drive we_o=0; any other func SHALL skip BUS, go directly to RESP with resp_err_o=1.
REQ-020 BUS: cyc_o=stb_o=1, adr_o={adr[AWID-1:4],4'h0}, sel_o=(size mask: byt 1, wyde 3, tetra F, octa FF, hexi FFFF, other FF) << adr[3:0], truncated to 16 bits.
REQ-021 dat_o SHALL be captured dat << (adr[3:0]*8), truncated to 128 bits; bytes beyond lane 15 dropped.
REQ-022 Bus outputs SHALL be constant for the whole BUS state; cyc_o/stb_o drop in the clock after termination.
REQ-023 ack_i in BUS SHALL terminate; loads SHALL register dat_i >> (adr[3:0]*8), masked to size; MR_LOAD sign-extends from top selected byte, MR_LOADZ zero-extends.
REQ-024 err_i in BUS SHALL terminate with resp_err_o=1; err_i with ack_i same clock: error wins.
REQ-025 RESP: resp_valid_o=1, resp_o/resp_err_o stable until resp_ready_i=1; then IDLE next clock.
REQ-026 Minimum occupancy per request SHALL be 3 clocks (IDLE, BUS with immediate ack, RESP with ready high).
REQ-027 Store responses SHALL return captured request with dat unchanged.

Reset
REQ-028 rst low SHALL immediately force IDLE and clear req_rd_o, cyc_o, stb_o, we_o, sel_o, resp_valid_o, resp_err_o, busy_o, timeout counter; adr_o, dat_o, resp_o SHALL reset to 0.
REQ-029 Reset mid-BUS SHALL abandon the cycle without response; the popped request is lost.

Configuration
REQ-030 Macro RFBW_MEM_REQ_DRAIN_TIMEOUT_EN: when defined, an 8-bit counter clears on BUS entry, increments each BUS clock without ack_i/err_i; reaching TOUT terminates with resp_err_o=1; ack_i in that same clock wins (no error).
REQ-031 Without the macro, no counter SHALL exist and BUS waits indefinitely.

Verification
REQ-032 Store octa adr 0x1008, dat 0x1122334455667788, ack after 2 clocks -> req_rd_o single pulse, sel_o=0xFF00, dat_o[127:64]=0x1122334455667788, we_o=1, resp_err_o=0.
REQ-033 MR_LOAD byt adr 0x2003, dat_i byte3=0x80 -> resp_o.dat=all-ones except low byte 0x80; MR_LOADZ same -> 0x80.
REQ-034 err_i and ack_i same clock on load -> resp_err_o=1; resp held 5 clocks with resp_ready_i=0, unchanged, no pop.
REQ-035 TIMEOUT_EN, TOUT=16, no ack -> cyc_o drops after 16 BUS clocks, resp_err_o=1; ack on 16th clock -> resp_err_o=0.
REQ-036 rst low during BUS -> cyc_o=0 and resp_valid_o=0 asynchronously; next request after release serviced normally; invalid func -> pop, no cyc_o, resp_err_o=1.
